// File: rtl/dap_swj_pins_ctrl.sv
// DAP_SWJ_Pins controller: AHB register window plus the pin drive / wait / done sequencer.
// Optional feature macro: DAP_SWJ_PINS_WAIT_EN enables PINS_WAIT and the pin-match wait with timeout.
module dap_swj_pins_ctrl #(
  parameter int unsigned ADDRWIDTH    = 12,
  parameter int unsigned BASE_ADDR    = 0,
  parameter int unsigned JTAG_DEV_NUM = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 us_tick,
  input  logic                 ahb_write_en,
  input  logic [ADDRWIDTH-1:0] ahb_addr,
  input  logic [31:0]          ahb_wdata,
  input  logic [3:0]           ahb_byte_strobe,
  output logic [31:0]          ahb_rdata,
  input  logic                 start,
  output logic                 done,
  output logic                 SWCLK_TCK_O,
  output logic                 SWDIO_TMS_O,
  output logic                 TDI_O,
  output logic                 TRST_O,
  output logic                 SRST_O,
  input  logic                 SWDIO_TMS_I,
  input  logic                 SWO_TDO_I,
  input  logic                 TRST_I,
  input  logic                 SRST_I
);

  localparam int unsigned AW = ADDRWIDTH - 2;
`ifdef DAP_SWJ_PINS_WAIT_EN
  localparam int unsigned WAIT_W   = 22;
  localparam logic [31:0] WAIT_MAX = 32'd3000000;
  localparam logic [7:0]  PIN_MASK = 8'hAF;
`endif

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_WAIT, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [31:0]         swj_cr_q, swj_cr_d;
  logic [8:0]          swd_cr_q, swd_cr_d;
  logic [4:0]          jtag_cr_q, jtag_cr_d;
  logic [15:0]         pins_cr_q, pins_cr_d;
  logic [31:0]         ir_q [JTAG_DEV_NUM];
  logic [31:0]         ir_d [JTAG_DEV_NUM];
`ifdef DAP_SWJ_PINS_WAIT_EN
  logic [WAIT_W-1:0]   pins_wait_q, pins_wait_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  logic                match_c;
`endif
  logic [3:0]          sync1_q, sync1_d, sync2_q, sync2_d;
  logic                swclk_q, swclk_d, swdio_q, swdio_d, tdi_q, tdi_d;
  logic                trst_q, trst_d, srst_q, srst_d;
  logic                done_q, done_d, busy_q, busy_d, timeout_q, timeout_d;
  logic [7:0]          sr_pins_q, sr_pins_d;
  logic [ADDRWIDTH-1:0] offset_c;
  logic [AW-1:0]       word_c;
  logic [31:0]         rdata_c, merged_c;
  logic [7:0]          sample_c, pin_val_c, pin_sel_c;
  logic                finish_c;
  logic                unused_c;

  function automatic logic [31:0] merge_lanes(input logic [31:0] cur, input logic [31:0] wd,
                                              input logic [3:0] be);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  assign offset_c  = ahb_addr - ADDRWIDTH'(BASE_ADDR);
  assign word_c    = offset_c[ADDRWIDTH-1:2];
  assign pin_val_c = pins_cr_q[7:0];
  assign pin_sel_c = pins_cr_q[15:8];
  // Output-only pins (SWCLK, TDI) sense their own drive; the rest come through the synchronisers.
  assign sample_c  = {sync2_q[3], 1'b0, sync2_q[2], 1'b0, sync2_q[1], tdi_q, sync2_q[0], swclk_q};
`ifdef DAP_SWJ_PINS_WAIT_EN
  assign match_c   = (((sample_c ^ pin_val_c) & pin_sel_c & PIN_MASK) == 8'h00);
  assign unused_c  = ^offset_c[1:0];
`else
  assign unused_c  = ^{offset_c[1:0], us_tick};
`endif

  // Register read mux; unimplemented bits and holes read zero.
  always_comb begin
    rdata_c = '0;
    case (word_c)
      AW'(0): rdata_c = swj_cr_q;
      AW'(1): rdata_c = {23'h0, swd_cr_q};
      AW'(2): rdata_c = {27'h0, jtag_cr_q};
      AW'(3): rdata_c = {16'h0, pins_cr_q};
`ifdef DAP_SWJ_PINS_WAIT_EN
      AW'(4): rdata_c = {10'h0, pins_wait_q};
`endif
      AW'(5): rdata_c = {22'h0, timeout_q, busy_q, sr_pins_q};
      default: begin
        for (int unsigned n = 0; n < JTAG_DEV_NUM; n++) begin
          if (word_c == AW'(8 + n)) rdata_c = ir_q[n];
        end
      end
    endcase
  end

  // Byte-lane register writes with clamping; pin command registers frozen while busy.
  always_comb begin
    swj_cr_d  = swj_cr_q;
    swd_cr_d  = swd_cr_q;
    jtag_cr_d = jtag_cr_q;
    pins_cr_d = pins_cr_q;
    ir_d      = ir_q;
`ifdef DAP_SWJ_PINS_WAIT_EN
    pins_wait_d = pins_wait_q;
`endif
    merged_c  = merge_lanes(rdata_c, ahb_wdata, ahb_byte_strobe);
    if (ahb_write_en) begin
      case (word_c)
        AW'(0): swj_cr_d = merged_c;
        AW'(1): swd_cr_d = merged_c[8:0];
        AW'(2): jtag_cr_d = (merged_c > 32'(JTAG_DEV_NUM)) ? 5'(JTAG_DEV_NUM) : merged_c[4:0];
        AW'(3): if (!busy_q) pins_cr_d = merged_c[15:0];
`ifdef DAP_SWJ_PINS_WAIT_EN
        AW'(4): if (!busy_q) pins_wait_d = (merged_c > WAIT_MAX) ? WAIT_W'(WAIT_MAX)
                                                                   : merged_c[WAIT_W-1:0];
`endif
        default: begin
          for (int unsigned n = 0; n < JTAG_DEV_NUM; n++) begin
            if (word_c == AW'(8 + n)) ir_d[n] = merged_c;
          end
        end
      endcase
    end
  end

  // Sequencer; pin drive and counter load are registered on the IDLE->APPLY edge.
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    timeout_d = timeout_q;
    sr_pins_d = sr_pins_q;
    swclk_d   = swclk_q;
    swdio_d   = swdio_q;
    tdi_d     = tdi_q;
    trst_d    = trst_q;
    srst_d    = srst_q;
    sync1_d   = {SRST_I, TRST_I, SWO_TDO_I, SWDIO_TMS_I};
    sync2_d   = sync1_q;
    finish_c  = 1'b0;
`ifdef DAP_SWJ_PINS_WAIT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_APPLY;
          busy_d    = 1'b1;
          timeout_d = 1'b0;
          if (pin_sel_c[0]) swclk_d = pin_val_c[0];
          if (pin_sel_c[1]) swdio_d = pin_val_c[1];
          if (pin_sel_c[2]) tdi_d   = pin_val_c[2];
          if (pin_sel_c[5]) trst_d  = pin_val_c[5];
          if (pin_sel_c[7]) srst_d  = pin_val_c[7];
`ifdef DAP_SWJ_PINS_WAIT_EN
          cnt_d     = pins_wait_q;
`endif
        end
      end
      S_APPLY: state_d = S_WAIT;
      S_WAIT: begin
`ifdef DAP_SWJ_PINS_WAIT_EN
        // Match wins over a coincident final tick.
        if (cnt_q == '0 || match_c) begin
          finish_c = 1'b1;
        end else if (us_tick) begin
          cnt_d = cnt_q - WAIT_W'(1);
          if (cnt_q == WAIT_W'(1)) begin
            finish_c  = 1'b1;
            timeout_d = 1'b1;
          end
        end
`else
        finish_c = 1'b1;
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (finish_c) begin
      state_d   = S_DONE;
      done_d    = 1'b1;
      busy_d    = 1'b0;
      sr_pins_d = sample_c;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      swj_cr_q  <= '0;
      swd_cr_q  <= '0;
      jtag_cr_q <= '0;
      pins_cr_q <= '0;
      for (int unsigned n = 0; n < JTAG_DEV_NUM; n++) ir_q[n] <= '0;
`ifdef DAP_SWJ_PINS_WAIT_EN
      pins_wait_q <= '0;
      cnt_q       <= '0;
`endif
      sync1_q   <= '0;
      sync2_q   <= '0;
      swclk_q   <= 1'b0;
      swdio_q   <= 1'b1;
      tdi_q     <= 1'b1;
      trst_q    <= 1'b1;
      srst_q    <= 1'b1;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      sr_pins_q <= '0;
    end else begin
      state_q   <= state_d;
      swj_cr_q  <= swj_cr_d;
      swd_cr_q  <= swd_cr_d;
      jtag_cr_q <= jtag_cr_d;
      pins_cr_q <= pins_cr_d;
      ir_q      <= ir_d;
`ifdef DAP_SWJ_PINS_WAIT_EN
      pins_wait_q <= pins_wait_d;
      cnt_q       <= cnt_d;
`endif
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      swclk_q   <= swclk_d;
      swdio_q   <= swdio_d;
      tdi_q     <= tdi_d;
      trst_q    <= trst_d;
      srst_q    <= srst_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      sr_pins_q <= sr_pins_d;
    end
  end

  assign ahb_rdata   = rdata_c;
  assign done        = done_q;
  assign SWCLK_TCK_O = swclk_q;
  assign SWDIO_TMS_O = swdio_q;
  assign TDI_O       = tdi_q;
  assign TRST_O      = trst_q;
  assign SRST_O      = srst_q;

endmodule

// File: doc/dap_swj_pins_ctrl.md
DAP_SWJ_PINS_CTRL -- requirements
Module: dap_swj_pins_ctrl

Interface
REQ-001 Parameter ADDRWIDTH, default 12, is the width of the AHB memory-interface address.
REQ-002 Parameter BASE_ADDR, default 0, is the byte offset of register 0 within the window.
REQ-003 Parameter JTAG_DEV_NUM, default 8, is the number of JTAG IR config registers (legal range 1..16).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset: ports clk and resetn.
REQ-005 Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- us_tick  in  1  one-clk pulse per microsecond.
- ahb_write_en  in  1  register write qualifier.
- ahb_addr  in  ADDRWIDTH  byte address.
- ahb_wdata  in  32  write data.
- ahb_byte_strobe  in  4  byte lane enables.
- ahb_rdata  out  32  combinational read data.
- start  in  1  DAP_SWJ_Pins command start pulse.
- done  out  1  one-clk completion pulse.
- SWCLK_TCK_O, SWDIO_TMS_O, TDI_O, TRST_O, SRST_O  out  1 each  pin drive.
- SWDIO_TMS_I, SWO_TDO_I, TRST_I, SRST_I  in  1 each  pin sense (asynchronous).

Function
REQ-006 Registers (offsets from BASE_ADDR; words decoded on ahb_addr[ADDRWIDTH-1:2]):
- 0x000 SWJ_CR RW [31:0].
- 0x004 SWD_CR RW [8:0].
- 0x008 JTAG_CR RW [4:0] device count.
- 0x00C PINS_CR RW: [7:0] value, [15:8] select.
- 0x010 PINS_WAIT RW [21:0], in us.
- 0x014 PINS_SR RO: [7:0] pin sample, [8] busy, [9] timeout.
- 0x020+4n JTAG_IR_CONF[n] RW [31:0], n<JTAG_DEV_NUM.
- Unmapped or n>=JTAG_DEV_NUM addresses read 0.
REQ-007 Register writes SHALL occur only when ahb_write_en=1, per byte lane enabled in ahb_byte_strobe; bits not implemented SHALL read 0.
REQ-008 A JTAG_CR write above JTAG_DEV_NUM SHALL store JTAG_DEV_NUM.
REQ-009 A PINS_WAIT write above 3000000 SHALL store 3000000.
REQ-010 Writes to PINS_CR or PINS_WAIT while busy=1 SHALL be ignored.
REQ-011 Pin bit map: 0 SWCLK/TCK, 1 SWDIO/TMS, 2 TDI, 3 TDO, 5 nTRST, 7 nRESET; bits 4 and 6 read 0.
REQ-012 Pin inputs SHALL pass through 2-flop synchronisers; TDI, SWCLK and the sense of an output-only pin read back its driven value.
REQ-013 FSM IDLE->APPLY->WAIT->DONE->IDLE, with start sampled only in IDLE; start in any other state SHALL be ignored.
REQ-014 APPLY (1 clk): each output with select bit 1 SHALL take its value bit; the counter SHALL load PINS_WAIT; busy=1; timeout cleared.
REQ-015 WAIT, PINS_WAIT=0: exit to DONE on the next clk.
REQ-016 WAIT, PINS_WAIT>0, exit to DONE when (sample & select)==(value & select) over bits 0,1,2,3,5,7 (no timeout).
REQ-017 WAIT, PINS_WAIT>0, otherwise: decrement on each us_tick; when the counter reaches 0 with no match, set timeout=1 and exit to DONE.
REQ-018 A match and the final tick in the same clk SHALL resolve as a match (timeout=0).
REQ-019 DONE: PINS_SR[7:0] latches the sample, done=1 for exactly one clk, busy clears, then return to IDLE.
REQ-020 Latency with PINS_WAIT=0: start in clk N -> pins updated N+1 -> done in N+3.

Reset
REQ-021 resetn low SHALL asynchronously reset the block:
- all registers 0; FSM IDLE; done 0; busy 0; timeout 0.
- SWCLK_TCK_O 0, SWDIO_TMS_O 1, TDI_O 1, TRST_O 1, SRST_O 1.
REQ-022 Reset mid-command SHALL abort the command with no done pulse.

Configuration
REQ-023 Macro DAP_SWJ_PINS_WAIT_EN defined: REQ-015..018 as stated.
REQ-024 Macro DAP_SWJ_PINS_WAIT_EN undefined:
- PINS_WAIT is not implemented and reads 0.
- WAIT always exits after 1 clk; timeout is never set.

Verification
REQ-025 Register writes: write 0xFFFFFFFF, strobe 0x3, to SWD_CR -> reads 0x1FF; write JTAG_CR=20 with JTAG_DEV_NUM=8 -> reads 8; read JTAG_IR_CONF[8] -> 0.
REQ-026 ahb_wdata=0x12345678 with ahb_write_en=0 to SWJ_CR -> SWJ_CR stays 0.
REQ-027 PINS_CR=0x8080 (nRESET drive 1 with select), WAIT=0, start -> SRST_O=1 one clk after start, done 3 clk after start, only bit 7 changed.
REQ-028 PINS_CR=0x8000 (select nRESET, value 0), WAIT=10, SRST_I held 1 -> done after 10 us_ticks with timeout=1 and PINS_SR[7]=1.
REQ-029 Same as REQ-028, SRST_I driven 0 after 4 ticks -> done within 3 clk of sync, timeout=0.
REQ-030 Resilience: start pulsed while busy -> ignored, exactly one done; resetn dropped in WAIT -> outputs return to reset values, no done.
